// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, start/busy handshake.
// Quotient bits shift into the dividend register; sign fix-up happens in FIX.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_a_orig;
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_zero;
   logic [CW-1:0]    r_count;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_q_final;
   logic [WIDTH-1:0] w_r_final;

   assign w_a_neg = i_is_signed & i_a[WIDTH-1];
   assign w_b_neg = i_is_signed & i_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
   assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

   // Partial remainder stays below the divisor, so the difference always fits in WIDTH bits.
   assign w_shift = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

   assign w_q_final = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
   assign w_r_final = r_sign_r ? (~r_rem + 1'b1) : r_rem;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_dvd         <= '0;
         r_dvs         <= '0;
         r_rem         <= '0;
         r_a_orig      <= '0;
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_zero        <= 1'b0;
         r_count       <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_div_by_zero <= 1'b0;
         o_quotient    <= '0;
         o_remainder   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  r_dvd         <= w_a_mag;
                  r_dvs         <= w_b_mag;
                  r_rem         <= '0;
                  r_a_orig      <= i_a;
                  r_sign_q      <= w_a_neg ^ w_b_neg;
                  r_sign_r      <= w_a_neg;
                  r_zero        <= (i_b == '0);
                  r_count       <= CW'(WIDTH);
                  o_busy        <= 1'b1;
                  o_div_by_zero <= 1'b0;
                  r_state       <= S_RUN;
               end
            end
            S_RUN: begin
               r_rem   <= w_ge ? w_diff : w_shift[WIDTH-1:0];
               r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               // Divide by zero returns all ones and the untouched dividend.
               o_quotient    <= r_zero ? '1 : w_q_final;
               o_remainder   <= r_zero ? r_a_orig : w_r_final;
               o_div_by_zero <= r_zero;
               o_busy        <= 1'b0;
               o_done        <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed and random checks for divider; expected results queued at start, compared at done.
module tb_divider;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   exp_t scoreboard[$];
   int   checks = 0;
   int   errors = 0;

   divider #(.WIDTH(32)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_is_signed   (is_signed),
      .i_a           (a),
      .i_b           (b),
      .o_busy        (busy),
      .o_done        (done),
      .o_div_by_zero (div_by_zero),
      .o_quotient    (quotient),
      .o_remainder   (remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int intrude);
      exp_t e;
      int   cyc;
      bit   seen;
      @(negedge clk);
      a = ta; b = tb_v; is_signed = ts; start = 1'b1;
      e.q = eq; e.r = er; e.dbz = edbz;
      scoreboard.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      check({tag, "_dbz_cleared"}, 32'(div_by_zero), 32'd0);
      cyc = 1;
      seen = 0;
      for (int i = 2; i < 100 && !seen; i++) begin
         if (i == intrude) begin
            start = 1'b1; a = ~ta; b = 32'd3; is_signed = ~ts;
         end else if (i == intrude + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) seen = 1;
         else if (busy) cyc++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
      check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
      check({tag, "_sb_nonempty"}, 32'(scoreboard.size()), 32'd1);
      if (scoreboard.size() != 0) begin
         e = scoreboard.pop_front();
         check({tag, "_q"}, quotient, e.q);
         check({tag, "_r"}, remainder, e.r);
         check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
      end
      $display("op %s a=%h b=%h s=%b q=%h r=%h dbz=%b busy_cycles=%0d",
               tag, ta, tb_v, ts, quotient, remainder, div_by_zero, cyc);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] eq;
      logic [31:0] er;
      int          sa;
      int          sbv;
      bit          saw_done;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_q", quotient, 32'd0);
      check("rst_r", remainder, 32'd0);
      rst_n = 1'b1;

      run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0);
      run_op("s-77_5", 32'hFFFF_FFB3, 32'd5, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFE, 1'b0, 0);
      run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 0);
      run_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 0);
      run_op("u_big_16", 32'hF398_F1AB, 32'h10, 1'b0, 32'h0F39_8F1A, 32'hB, 1'b0, 0);
      run_op("s1234_0", 32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0);

      repeat (5) @(negedge clk);
      check("hold_dbz", 32'(div_by_zero), 32'd1);
      check("hold_q", quotient, 32'hFFFF_FFFF);
      check("hold_r", remainder, 32'd1234);

      run_op("s-9_0", 32'hFFFF_FFF7, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 0);
      run_op("u1000_10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 0);
      run_op("u500_3_intr", 32'd500, 32'd3, 1'b0, 32'd166, 32'd2, 1'b0, 10);
      run_op("s100_-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (rb == 0) rb = 32'd1;
         if (i < 4) begin
            eq = ra / rb;
            er = ra % rb;
            run_op("rand_u", ra, rb, 1'b0, eq, er, 1'b0, 0);
         end else begin
            sa = ra;
            sbv = rb;
            if (sa == 32'sh8000_0000 && sbv == -1) sbv = 3;
            eq = 32'(sa / sbv);
            er = 32'(sa % sbv);
            run_op("rand_s", ra, 32'(sbv), 1'b1, eq, er, 1'b0, 0);
         end
      end

      @(negedge clk);
      a = 32'd50000; b = 32'd7; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_dbz", 32'(div_by_zero), 32'd0);
      check("midrst_q", quotient, 32'd0);
      check("midrst_r", remainder, 32'd0);
      $display("op midrst a=%h b=%h busy=%b q=%h r=%h", a, b, busy, quotient, remainder);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1;
      end
      check("midrst_no_resume", 32'(saw_done), 32'd0);
      check("midrst_q_held", quotient, 32'd0);

      run_op("u81_9_after_rst", 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
